// File: rtl/ysyx_22050598_ifu_ctrl.sv
// Instruction-fetch control: owns the PC, fetches over a req/resp imem port, handles redirect/halt.
// Optional misaligned-jump halt enabled by defining YSYX_22050598_IFU_MISALIGN_CHK_EN.
module ysyx_22050598_ifu_ctrl #(
  parameter int               XLEN        = 64,
  parameter logic [XLEN-1:0]  RESET_PC    = 64'h8000_0000,
  parameter logic [63:0]      INSTRET_RST = 64'd0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            inst_valid,
  input  logic            j_flag,
  input  logic [XLEN-1:0] j_pc,
  input  logic            ebreak_flag,
  output logic            halt,
  output logic            misalign,
  output logic [63:0]     instret
);

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    EXEC,
    HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            inst_valid_q, inst_valid_d;
  logic            req_valid_q, req_valid_d;
  logic            halt_q, halt_d;
  logic            misalign_q, misalign_d;
  logic [63:0]     instret_q, instret_d;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc = pc_q + {{(XLEN-3){1'b0}}, 3'd4};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    req_valid_d  = 1'b0;
    halt_d       = halt_q;
    misalign_d   = misalign_q;
    instret_d    = instret_q;
    unique case (state_q)
      BOOT: begin
        state_d     = REQ;
        req_valid_d = 1'b1;
      end
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
        else req_valid_d = 1'b1;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          inst_d       = imem_resp_data;
          inst_valid_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        instret_d = instret_q + 64'd1;
        if (ebreak_flag) begin
          state_d = HALT;
          halt_d  = 1'b1;
        end else if (j_flag) begin
          pc_d        = j_pc;
          state_d     = REQ;
          req_valid_d = 1'b1;
`ifdef YSYX_22050598_IFU_MISALIGN_CHK_EN
          // Keep the faulting target in pc so debug can see where it went.
          if (j_pc[1:0] != 2'b00) begin
            state_d     = HALT;
            req_valid_d = 1'b0;
            halt_d      = 1'b1;
            misalign_d  = 1'b1;
          end
`endif
        end else begin
          pc_d        = pc_inc;
          state_d     = REQ;
          req_valid_d = 1'b1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      req_valid_q  <= 1'b0;
      halt_q       <= 1'b0;
      misalign_q   <= 1'b0;
      instret_q    <= INSTRET_RST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      req_valid_q  <= req_valid_d;
      halt_q       <= halt_d;
      misalign_q   <= misalign_d;
      instret_q    <= instret_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign inst_valid     = inst_valid_q;
  assign halt           = halt_q;
  assign misalign       = misalign_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_ysyx_22050598_ifu_ctrl.sv
// Directed bench for ysyx_22050598_ifu_ctrl with an address scoreboard.
// A second instance with a preloaded retire counter exercises the 64-bit wrap.
module tb_ysyx_22050598_ifu_ctrl;

`ifdef YSYX_22050598_IFU_MISALIGN_CHK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif
  localparam logic [63:0] RPC    = 64'h8000_0000;
  localparam logic [63:0] W_INIT = 64'hFFFF_FFFF_FFFF_FFFE;

  logic        clk;
  logic        rst;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        j_flag;
  logic [63:0] j_pc;
  logic        ebreak_flag;

  logic        imem_req_valid, inst_valid, halt, misalign;
  logic [63:0] imem_req_addr, pc, instret;
  logic [31:0] inst;

  logic        w_req_valid, w_inst_valid, w_halt, w_misalign;
  logic [63:0] w_req_addr, w_pc, w_instret;
  logic [31:0] w_inst;

  int          checks;
  int          errors;
  logic [63:0] addr_q[$];
  logic [63:0] exp_instret;

  ysyx_22050598_ifu_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst(inst), .pc(pc),
    .inst_valid(inst_valid), .j_flag(j_flag), .j_pc(j_pc),
    .ebreak_flag(ebreak_flag), .halt(halt), .misalign(misalign),
    .instret(instret)
  );

  ysyx_22050598_ifu_ctrl #(.INSTRET_RST(W_INIT)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst(w_inst), .pc(w_pc),
    .inst_valid(w_inst_valid), .j_flag(j_flag), .j_pc(j_pc),
    .ebreak_flag(ebreak_flag), .halt(w_halt), .misalign(w_misalign),
    .instret(w_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    addr_q.delete();
    addr_q.push_back(RPC);
    exp_instret = 64'd0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid === 1'b1) break;
      @(negedge clk);
    end
    if (imem_req_valid !== 1'b1) chk("req_timeout", imem_req_valid, 64'd1);
  endtask

  task automatic fetch(input logic [31:0] data, input logic jf,
                       input logic [63:0] jpc, input logic eb);
    logic [63:0] exp;
    logic        mis;
    wait_req();
    exp = (addr_q.size() > 0) ? addr_q.pop_front() : 64'hDEAD;
    chk("req_addr", imem_req_addr, exp);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("req_drop", imem_req_valid, 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    chk("inst_valid", inst_valid, 64'd1);
    chk("inst", inst, data);
    chk("pc", pc, exp);
    chk("instret_pre", instret, exp_instret);
    j_flag      = jf;
    j_pc        = jpc;
    ebreak_flag = eb;
    @(negedge clk);
    j_flag      = 1'b0;
    ebreak_flag = 1'b0;
    exp_instret = exp_instret + 64'd1;
    chk("inst_valid_1cyc", inst_valid, 64'd0);
    chk("instret", instret, exp_instret);
    chk("w_instret", w_instret, W_INIT + exp_instret);
    mis = MCHK && jf && !eb && (jpc[1:0] != 2'b00);
    if (eb || mis) begin
      chk("halt", halt, 64'd1);
      chk("misalign", misalign, {63'd0, mis});
      chk("halt_pc", pc, eb ? exp : jpc);
      chk("halt_noreq", imem_req_valid, 64'd0);
    end else begin
      chk("no_halt", halt, 64'd0);
      chk("misalign0", misalign, 64'd0);
      chk("next_req", imem_req_valid, 64'd1);
      addr_q.push_back(jf ? jpc : exp + 64'd4);
    end
  endtask

  initial begin
    logic [63:0] held;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    j_flag      = 1'b0;
    j_pc        = 64'd0;
    ebreak_flag = 1'b0;
    exp_instret = 64'd0;
    @(negedge clk);
    do_reset();

    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 64'd0);
    chk("rst_inst_valid", inst_valid, 64'd0);
    chk("rst_req_valid", imem_req_valid, 64'd0);
    chk("rst_halt", halt, 64'd0);
    chk("rst_misalign", misalign, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_w_instret", w_instret, W_INIT);
    @(negedge clk);
    chk("boot_to_req", imem_req_valid, 64'd1);

    fetch(32'h0000_0413, 1'b0, 64'd0, 1'b0);

    held = imem_req_addr;
    for (int i = 0; i < 3; i++) begin
      imem_resp_valid = (i == 1);
      imem_resp_data  = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("stall_valid", imem_req_valid, 64'd1);
      chk("stall_addr", imem_req_addr, held);
      chk("stall_no_inst", inst_valid, 64'd0);
    end
    imem_resp_valid = 1'b0;

    fetch(32'h0000_0093, 1'b1, 64'h8000_0100, 1'b0);
    chk("instret_wrap", w_instret, 64'd0);
    fetch(32'h0010_0113, 1'b0, 64'd0, 1'b0);

    fetch(32'h0000_0067, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    fetch(32'h0000_0013, 1'b0, 64'd0, 1'b0);
    fetch(32'h0000_0013, 1'b0, 64'd0, 1'b0);

    fetch(32'h0000_00E7, 1'b1, 64'h8000_0102, 1'b0);
    if (!MCHK) fetch(32'h0000_0013, 1'b0, 64'd0, 1'b0);
    do_reset();

    fetch(32'h0000_0013, 1'b0, 64'd0, 1'b0);
    wait_req();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wrst_instret", instret, 64'd0);
    chk("wrst_pc", pc, RPC);
    chk("wrst_req_valid", imem_req_valid, 64'd0);
    chk("wrst_inst_valid", inst_valid, 64'd0);
    addr_q.delete();
    addr_q.push_back(RPC);
    exp_instret = 64'd0;

    fetch(32'h0000_0013, 1'b0, 64'd0, 1'b0);
    fetch(32'h0010_0073, 1'b1, 64'h8000_0200, 1'b1);
    for (int i = 0; i < 20; i++) begin
      imem_req_ready  = i[0];
      imem_resp_valid = i[1];
      @(negedge clk);
      chk("halt_idle_req", imem_req_valid, 64'd0);
      chk("halt_sticky", halt, 64'd1);
      chk("halt_no_inst", inst_valid, 64'd0);
    end
    chk("halt_pc_final", pc, RPC + 64'd4);
    chk("halt_instret", instret, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
